jzjpcc_parametrised_sram: RTL and testbench

Generalised dual-port synchronous SRAM for the jzjpcc memory backend, replacing the fixed 32-bit, single-latency inferred SRAM. It adds parametrised data width and depth, per-byte write enables, an optional output register stage, read-valid tracking and a post-reset zero-fill sequencer. Both the instruction-fetch and data-access paths of the core sit on its two ports.

---
 rtl/jzjpcc_parametrised_sram.sv | 153 +++++++++++++++
 tb/tb_jzjpcc_parametrised_sram.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jzjpcc_parametrised_sram.sv
// +----------------------------------------------------------------------------+
// | Module   : jzjpcc_parametrised_sram                                        |
// | Brief    : dual-port byte-writable SRAM with optional output register and  |
// |            post-reset zero-fill sequencer                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module jzjpcc_parametrised_sram #(
  parameter int DATA_WIDTH           = 32,
  parameter int RAM_A_WIDTH          = 12,
  parameter int OUTPUT_REG           = 0,
  parameter int CLEAR_ON_RESET       = 1,
  parameter     INITIAL_MEM_CONTENTS = "/tmp/test.hex"
) (
  input  logic                      clock,
  input  logic                      reset,
  output logic                      ready,
  input  logic [RAM_A_WIDTH-1:0]    addressA,
  input  logic [RAM_A_WIDTH-1:0]    addressB,
  input  logic                      readEnableA,
  input  logic                      readEnableB,
  input  logic                      writeEnableA,
  input  logic                      writeEnableB,
  input  logic [DATA_WIDTH/8-1:0]   byteEnableA,
  input  logic [DATA_WIDTH/8-1:0]   byteEnableB,
  input  logic [DATA_WIDTH-1:0]     writeA,
  input  logic [DATA_WIDTH-1:0]     writeB,
  output logic [DATA_WIDTH-1:0]     readA,
  output logic [DATA_WIDTH-1:0]     readB,
  output logic                      readValidA,
  output logic                      readValidB
);

  localparam int c_BYTES    = DATA_WIDTH / 8;
  localparam int c_NUM_ADDR = 2 ** RAM_A_WIDTH;

  localparam logic [0:0] c_ST_CLEAR = 1'b0;
  localparam logic [0:0] c_ST_READY = 1'b1;

  logic [DATA_WIDTH-1:0]  r_mem [c_NUM_ADDR];

  logic                   w_ready;
  logic [RAM_A_WIDTH-1:0] w_clear_addr;

  logic [RAM_A_WIDTH-1:0] w_wr_addr_a;
  logic [DATA_WIDTH-1:0]  w_wr_data_a;
  logic [c_BYTES-1:0]     w_wr_be_a;
  logic [c_BYTES-1:0]     w_wr_be_b;

  logic [1:0]             w_rd_acc;
  logic [RAM_A_WIDTH-1:0] w_rd_addr [2];
  logic [DATA_WIDTH-1:0]  r_rdata [2];
  logic [1:0]             r_valid1;

  // Zero-fill sweep; the array is only usable once every word has been cleared.
  if (CLEAR_ON_RESET != 0) begin : g_clear
    logic [0:0]             r_state;
    logic [RAM_A_WIDTH-1:0] r_clear_counter;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_state         <= c_ST_CLEAR;
        r_clear_counter <= '0;
      end else if (r_state == c_ST_CLEAR) begin
        r_clear_counter <= r_clear_counter + RAM_A_WIDTH'(1);
        if (r_clear_counter == {RAM_A_WIDTH{1'b1}}) begin
          r_state <= c_ST_READY;
        end
      end
    end

    assign w_ready      = (r_state == c_ST_READY);
    assign w_clear_addr = r_clear_counter;
  end else begin : g_no_clear
    assign w_ready      = 1'b1;
    assign w_clear_addr = '0;
  end

  assign ready = w_ready;

  // The sweep borrows port A's write path; port B is idle until ready.
  assign w_wr_addr_a = w_ready ? addressA : w_clear_addr;
  assign w_wr_data_a = w_ready ? writeA   : '0;
  assign w_wr_be_a   = w_ready ? (writeEnableA ? byteEnableA : '0) : '1;
  assign w_wr_be_b   = (w_ready && writeEnableB) ? byteEnableB : '0;

  // Port A is written last so it takes any byte both ports hit.
  always_ff @(posedge clock) begin
    for (int i = 0; i < c_BYTES; i++) begin
      if (w_wr_be_b[i]) begin
        r_mem[addressB][8*i +: 8] <= writeB[8*i +: 8];
      end
    end
    for (int i = 0; i < c_BYTES; i++) begin
      if (w_wr_be_a[i]) begin
        r_mem[w_wr_addr_a][8*i +: 8] <= w_wr_data_a[8*i +: 8];
      end
    end
  end

  assign w_rd_acc     = {w_ready & readEnableB, w_ready & readEnableA};
  assign w_rd_addr[0] = addressA;
  assign w_rd_addr[1] = addressB;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rdata[0] <= '0;
      r_rdata[1] <= '0;
      r_valid1   <= '0;
    end else begin
      r_valid1 <= w_rd_acc;
      for (int p = 0; p < 2; p++) begin
        if (w_rd_acc[p]) begin
          r_rdata[p] <= r_mem[w_rd_addr[p]];
        end
      end
    end
  end

  if (OUTPUT_REG != 0) begin : g_outreg
    logic [1:0]            r_valid2;
    logic [DATA_WIDTH-1:0] r_out [2];

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_out[0] <= '0;
        r_out[1] <= '0;
        r_valid2 <= '0;
      end else begin
        r_valid2 <= r_valid1;
        for (int p = 0; p < 2; p++) begin
          if (r_valid1[p]) begin
            r_out[p] <= r_rdata[p];
          end
        end
      end
    end

    assign readA      = r_out[0];
    assign readB      = r_out[1];
    assign readValidA = r_valid2[0];
    assign readValidB = r_valid2[1];
  end else begin : g_no_outreg
    assign readA      = r_rdata[0];
    assign readB      = r_rdata[1];
    assign readValidA = r_valid1[0];
    assign readValidB = r_valid1[1];
  end

endmodule

`default_nettype wire

// File: tb/tb_jzjpcc_parametrised_sram.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_jzjpcc_parametrised_sram                                     |
// | Brief    : directed bench, 1- and 2-cycle latency instances, shared stim   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_jzjpcc_parametrised_sram;

  localparam int c_DW  = 32;
  localparam int c_AW  = 4;
  localparam int c_NUM = 16;

  logic clk;
  logic rst;
  logic [c_AW-1:0] addrA, addrB;
  logic reA, reB, weA, weB;
  logic [3:0] beA, beB;
  logic [c_DW-1:0] wA, wB;

  logic ready0, ready1;
  logic [c_DW-1:0] rdA0, rdB0, rdA1, rdB1;
  logic rvA0, rvB0, rvA1, rvB1;

  int n_cmp  = 0;
  int n_fail = 0;

  jzjpcc_parametrised_sram #(.DATA_WIDTH(c_DW), .RAM_A_WIDTH(c_AW), .OUTPUT_REG(0),
    .CLEAR_ON_RESET(1)) u_dut0 (
    .clock(clk), .reset(rst), .ready(ready0),
    .addressA(addrA), .addressB(addrB), .readEnableA(reA), .readEnableB(reB),
    .writeEnableA(weA), .writeEnableB(weB), .byteEnableA(beA), .byteEnableB(beB),
    .writeA(wA), .writeB(wB), .readA(rdA0), .readB(rdB0),
    .readValidA(rvA0), .readValidB(rvB0)
  );

  jzjpcc_parametrised_sram #(.DATA_WIDTH(c_DW), .RAM_A_WIDTH(c_AW), .OUTPUT_REG(1),
    .CLEAR_ON_RESET(1)) u_dut1 (
    .clock(clk), .reset(rst), .ready(ready1),
    .addressA(addrA), .addressB(addrB), .readEnableA(reA), .readEnableB(reB),
    .writeEnableA(weA), .writeEnableB(weB), .byteEnableA(beA), .byteEnableB(beB),
    .writeA(wA), .writeB(wB), .readA(rdA1), .readB(rdB1),
    .readValidA(rvA1), .readValidB(rvB1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory contents, edges since reset release, and the
  // per-edge history of accepted reads viewed at latency 1 (dut0) and 2 (dut1).
  logic [31:0] m_mem [c_NUM];
  int          m_edges = 0;
  logic        e_ready = 1'b0;
  logic        hv0 [2];
  logic        hv1 [2];
  logic [31:0] hd0 [2];
  logic [31:0] hd1 [2];
  logic        e_v [2][2];
  logic [31:0] e_d [2][2];

  initial begin
    logic [c_AW-1:0] ad [2];
    logic            nv [2];
    logic [31:0]     nd [2];
    for (int i = 0; i < c_NUM; i++) m_mem[i] = '0;
    for (int p = 0; p < 2; p++) begin
      hv0[p] = 1'b0; hv1[p] = 1'b0; hd0[p] = '0; hd1[p] = '0;
      e_v[0][p] = 1'b0; e_v[1][p] = 1'b0; e_d[0][p] = '0; e_d[1][p] = '0;
    end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_edges = 0;
        e_ready = 1'b0;
        for (int p = 0; p < 2; p++) begin
          hv0[p] = 1'b0; hv1[p] = 1'b0;
          e_v[0][p] = 1'b0; e_v[1][p] = 1'b0; e_d[0][p] = '0; e_d[1][p] = '0;
        end
      end else begin
        ad[0] = addrA; ad[1] = addrB;
        nv[0] = e_ready && reA;
        nv[1] = e_ready && reB;
        nd[0] = m_mem[ad[0]];
        nd[1] = m_mem[ad[1]];
        if (!e_ready) begin
          m_mem[m_edges] = '0;
          m_edges++;
        end else begin
          for (int b = 0; b < 4; b++)
            if (weB && beB[b]) m_mem[addrB][8*b +: 8] = wB[8*b +: 8];
          for (int b = 0; b < 4; b++)
            if (weA && beA[b]) m_mem[addrA][8*b +: 8] = wA[8*b +: 8];
        end
        e_ready = (m_edges >= c_NUM);
        for (int p = 0; p < 2; p++) begin
          hv1[p] = hv0[p]; hd1[p] = hd0[p];
          hv0[p] = nv[p];  hd0[p] = nd[p];
          e_v[0][p] = hv0[p];
          if (hv0[p]) e_d[0][p] = hd0[p];
          e_v[1][p] = hv1[p];
          if (hv1[p]) e_d[1][p] = hd1[p];
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      chk("ready0", {31'd0, ready0}, {31'd0, e_ready});
      chk("ready1", {31'd0, ready1}, {31'd0, e_ready});
      chk("rvA0", {31'd0, rvA0}, {31'd0, e_v[0][0]});
      chk("rvB0", {31'd0, rvB0}, {31'd0, e_v[0][1]});
      chk("rvA1", {31'd0, rvA1}, {31'd0, e_v[1][0]});
      chk("rvB1", {31'd0, rvB1}, {31'd0, e_v[1][1]});
      chk("rdA0", rdA0, e_d[0][0]);
      chk("rdB0", rdB0, e_d[0][1]);
      chk("rdA1", rdA1, e_d[1][0]);
      chk("rdB1", rdB1, e_d[1][1]);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    reA = 0; reB = 0; weA = 0; weB = 0; beA = '0; beB = '0;
    addrA = '0; addrB = '0; wA = '0; wB = '0;
  endtask

  task automatic wrA(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    weA = 1; addrA = a; wA = d; beA = be;
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    idle();
    tick(); tick();
    chk("rst_ready0", {31'd0, ready0}, 32'd0);
    chk("rst_ready1", {31'd0, ready1}, 32'd0);
    chk("rst_rv", {28'd0, rvA0, rvB0, rvA1, rvB1}, 32'd0);
    chk("rst_rdA1", rdA1, 32'd0);

    // Requests during the sweep must be ignored; reset at clear cycle 9 restarts it.
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      weB = 1; addrB = '0; wB = 32'hDEAD0000 + i; beB = 4'hF;
      reA = 1; addrA = 4'(i); reB = 1;
      tick();
    end
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    cnt = 0;
    while (!ready0 && cnt < 40) begin
      weB = 1; addrB = '0; wB = 32'hBADC0FFE; beB = 4'hF; reA = 1; reB = 1;
      cnt++;
      tick();
    end
    chk("clear_len", cnt, 32'd16);
    idle();

    for (int a = 0; a < c_NUM; a++) begin
      reA = 1; addrA = 4'(a); reB = 1; addrB = 4'(15 - a);
      tick();
    end
    idle();
    tick(); tick();
    chk("clear_word0", rdB1, 32'd0);

    wrA(4'd3, 32'hAABBCCDD, 4'hF); tick();
    wrA(4'd3, 32'h11223344, 4'b0101); tick();
    idle(); reA = 1; addrA = 4'd3; tick();
    idle(); tick(); tick();
    chk("byte_merge_d0", rdA0, 32'hAA22CC44);
    chk("byte_merge_d1", rdA1, 32'hAA22CC44);
    chk("byte_merge_model", m_mem[3], 32'hAA22CC44);

    wrA(4'd5, 32'h12345678, 4'hF); tick();
    idle(); reA = 1; addrA = 4'd5; tick();
    idle();
    chk("lat1_valid", {30'd0, rvA0, rvA1}, 32'b10);
    chk("lat1_data", rdA0, 32'h12345678);
    tick();
    chk("lat2_valid", {30'd0, rvA0, rvA1}, 32'b01);
    chk("lat1_hold", rdA0, 32'h12345678);
    chk("lat2_data", rdA1, 32'h12345678);
    tick();
    chk("lat2_hold", {rvA1, rdA1[30:0]}, {1'b0, 31'h12345678});

    wrA(4'd7, 32'h000000FF, 4'b0011);
    weB = 1; addrB = 4'd7; wB = 32'hFFFFFFFF; beB = 4'b1110;
    tick();
    idle(); reA = 1; addrA = 4'd7; tick();
    idle(); tick(); tick();
    chk("collision_d0", rdA0, 32'hFFFF00FF);
    chk("collision_model", m_mem[7], 32'hFFFF00FF);

    wrA(4'd2, 32'h1, 4'hF); tick();
    wrA(4'd2, 32'h2, 4'hF); reB = 1; addrB = 4'd2; tick();
    idle(); reB = 1; addrB = 4'd2;
    chk("rdw_old", rdB0, 32'h1);
    tick();
    idle();
    chk("rdw_new", rdB0, 32'h2);
    tick();

    // Mixed full-throughput traffic on both ports.
    for (int i = 0; i < 32; i++) begin
      idle();
      weA = 1; addrA = 4'(i); wA = 32'h01010101 * i + 32'h00F0000F; beA = 4'(i) | 4'b0001;
      reA = (i % 2 == 0);
      reB = 1; addrB = 4'((i * 5) % 16);
      if (i % 3 == 0) begin
        weB = 1; wB = ~wA; beB = 4'b1111;
        addrB = 4'((i + 1) % 16);
      end
      tick();
    end
    idle(); tick(); tick();

    reA = 1; addrA = 4'd5; tick();
    idle();
    chk("pre_rst_valid", {31'd0, rvA0}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {30'd0, rvA0, rvA1}, 32'd0);
    chk("async_rst_data", rdA0, 32'd0);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
